// File: rtl/nexys_starship_spawn_sched.sv
// Monster spawn scheduler for the starship game.
// Runs a three-state game FSM, times the spawn interval for the current
// difficulty level, picks a free lane with an LFSR-seeded round-robin search,
// and issues a registered one-cycle, one-hot spawn request.
module nexys_starship_spawn_sched #(
  parameter logic [7:0] SEED             = 8'hA5,
  parameter int         SPAWNS_PER_LEVEL = 16
) (
  input  logic       timerClk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic [3:0] lane_busy,
  output logic [3:0] spawn,
  output logic [1:0] level,
  output logic [7:0] spawn_total,
  output logic       pending,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Halt
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    HALT = 3'b100
  } state_t;

  localparam logic [7:0] LVL_LAST = 8'(SPAWNS_PER_LEVEL - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  lfsr;
  logic [7:0]  lfsr_nxt;
  logic [7:0]  interval_cnt;
  logic [7:0]  lvl_cnt;
  logic [1:0]  level_r;
  logic [7:0]  total_r;
  logic [3:0]  pick_p0;
  logic [3:0]  spawn_p1;
  logic        found;
  logic [1:0]  idx;
  logic        run_st;
  logic        at_last;
  logic        eligible;
  logic        fire;
  logic        start_game;

  // Last count value of the interval for a level (interval length minus one).
  function automatic logic [7:0] interval_last(input logic [1:0] lv);
    case (lv)
      2'd0:    return 8'd199;
      2'd1:    return 8'd149;
      2'd2:    return 8'd99;
      default: return 8'd59;
    endcase
  endfunction

  // Increment that sticks at the limit.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  // Level increment that sticks at the hardest level.
  function automatic logic [1:0] sat_inc_level(input logic [1:0] lv);
    return (lv == 2'd3) ? 2'd3 : lv + 2'd1;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] b);
    return {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]};
  endfunction

  assign run_st     = (state == RUN);
  assign start_game = (state == IDLE) && play_flag;
  assign at_last    = (interval_cnt == interval_last(level_r));
  assign eligible   = run_st && at_last &&
                      (popcount4(lane_busy) < ({1'b0, level_r} + 3'd1)) &&
                      (lane_busy != 4'hF);
  // A game loss on the deciding edge suppresses the spawn.
  assign fire       = eligible && !game_over;
  assign pending    = run_st && at_last && !eligible;

  assign spawn       = spawn_p1;
  assign level       = level_r;
  assign spawn_total = total_r;

  // Taps 8,6,5,4; the zero guard only matters if the seed itself were zero.
  always_comb begin
    lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    if (lfsr_nxt == 8'h00) lfsr_nxt = 8'h01;
  end

  // LFSR free-runs on every edge regardless of game state.
  always_ff @(posedge timerClk or posedge Reset) begin
    if (Reset) lfsr <= SEED;
    else       lfsr <= lfsr_nxt;
  end

  // Lane search: start at lfsr[1:0], walk upward mod 4, take the first free lane.
  always_comb begin
    pick_p0 = 4'b0000;
    found   = 1'b0;
    idx     = lfsr[1:0];
    for (int k = 0; k < 4; k++) begin
      idx = lfsr[1:0] + 2'(k);
      if (!found && !lane_busy[idx]) begin
        pick_p0[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Game state register.
  always_ff @(posedge timerClk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and one-hot state outputs; illegal encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    q_Idle    = 1'b0;
    q_Run     = 1'b0;
    q_Halt    = 1'b0;
    case (state)
      IDLE: begin
        q_Idle = 1'b1;
        if (play_flag) state_nxt = RUN;
      end
      RUN: begin
        q_Run = 1'b1;
        if (game_over) state_nxt = HALT;
      end
      HALT: begin
        q_Halt = 1'b1;
        if (!play_flag) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: registered spawn pulse, interval timer, level and totals ----
  always_ff @(posedge timerClk or posedge Reset) begin
    if (Reset) begin
      spawn_p1     <= 4'b0000;
      interval_cnt <= 8'd0;
      lvl_cnt      <= 8'd0;
      level_r      <= 2'd0;
      total_r      <= 8'd0;
    end else begin
      spawn_p1 <= fire ? pick_p0 : 4'b0000;
      if (start_game) begin
        interval_cnt <= 8'd0;
        lvl_cnt      <= 8'd0;
        level_r      <= 2'd0;
        total_r      <= 8'd0;
      end else if (run_st && !game_over) begin
        if (fire) begin
          // New level applies to the interval that starts now.
          interval_cnt <= 8'd0;
          total_r      <= total_r + 8'd1;
          if (lvl_cnt == LVL_LAST) begin
            lvl_cnt <= 8'd0;
            level_r <= sat_inc_level(level_r);
          end else begin
            lvl_cnt <= lvl_cnt + 8'd1;
          end
        end else begin
          interval_cnt <= sat_inc8(interval_cnt, interval_last(level_r));
        end
      end
    end
  end

endmodule

// File: tb/tb_nexys_starship_spawn_sched.sv
// Bench for the spawn scheduler: directed scenarios plus randomized lane
// occupancy, game-over and play toggling, all scored against a rule-level model.
module tb_nexys_starship_spawn_sched;

  logic       timerClk = 1'b0;
  logic       Reset;
  logic       play_flag;
  logic       game_over;
  logic [3:0] lane_busy;
  logic [3:0] spawn;
  logic [1:0] level;
  logic [7:0] spawn_total;
  logic       pending;
  logic       q_Idle, q_Run, q_Halt;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: 0 idle, 1 run, 2 halt
  int         ms;
  int         m_cnt;
  int         m_level;
  int         m_lvlcnt;
  int         m_total;
  logic [7:0] m_lfsr;
  logic [3:0] m_spawn;

  nexys_starship_spawn_sched dut (
    .timerClk    (timerClk),
    .Reset       (Reset),
    .play_flag   (play_flag),
    .game_over   (game_over),
    .lane_busy   (lane_busy),
    .spawn       (spawn),
    .level       (level),
    .spawn_total (spawn_total),
    .pending     (pending),
    .q_Idle      (q_Idle),
    .q_Run       (q_Run),
    .q_Halt      (q_Halt)
  );

  always #5 timerClk = ~timerClk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int interval_of(input int lv);
    case (lv)
      0:       return 200;
      1:       return 150;
      2:       return 100;
      default: return 60;
    endcase
  endfunction

  function automatic int n_busy(input logic [3:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(b[i]);
    return s;
  endfunction

  function automatic bit m_at_last();
    return (ms == 1) && (m_cnt == interval_of(m_level) - 1);
  endfunction

  function automatic bit m_elig(input logic [3:0] b);
    return m_at_last() && (n_busy(b) < m_level + 1) && (b != 4'hF);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'hB8);
    return ((v << 1) & 8'hFE) | {7'd0, fb};
  endfunction

  task automatic model_reset();
    ms = 0; m_cnt = 0; m_level = 0; m_lvlcnt = 0; m_total = 0;
    m_lfsr = 8'hA5; m_spawn = 4'h0;
  endtask

  task automatic model_edge();
    logic [7:0] nl;
    int start, lane;
    if (Reset) begin
      model_reset();
      return;
    end
    nl = lfsr_step(m_lfsr);
    m_spawn = 4'h0;
    case (ms)
      0: if (play_flag) begin
        ms = 1; m_cnt = 0; m_level = 0; m_lvlcnt = 0; m_total = 0;
      end
      1: begin
        if (game_over) ms = 2;
        else if (m_at_last()) begin
          if (m_elig(lane_busy)) begin
            start = int'(m_lfsr[1:0]);
            lane = -1;
            for (int k = 0; k < 4; k++)
              if (lane < 0 && !lane_busy[(start + k) % 4]) lane = (start + k) % 4;
            m_spawn = 4'(1 << lane);
            m_cnt = 0;
            m_total = (m_total + 1) % 256;
            m_lvlcnt++;
            if (m_lvlcnt == 16) begin
              m_lvlcnt = 0;
              if (m_level < 3) m_level++;
            end
          end
        end else m_cnt++;
      end
      default: if (!play_flag) ms = 0;
    endcase
    m_lfsr = nl;
  endtask

  task automatic compare_all();
    check_eq("spawn", int'(spawn), int'(m_spawn));
    check_eq("level", int'(level), m_level);
    check_eq("spawn_total", int'(spawn_total), m_total);
    check_eq("pending", int'(pending), int'(m_at_last() && !m_elig(lane_busy)));
    check_eq("state", int'({q_Idle, q_Run, q_Halt}), (ms == 0) ? 4 : (ms == 1) ? 2 : 1);
  endtask

  task automatic step();
    @(posedge timerClk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_until_spawn(output int n, input int limit);
    n = 0;
    do begin
      step();
      n++;
    end while (spawn == 4'h0 && n < limit);
  endtask

  initial begin
    int n, k;
    Reset = 1'b1; play_flag = 1'b0; game_over = 1'b0; lane_busy = 4'h0;
    model_reset();
    #2;
    compare_all();
    check_eq("reset_lfsr", int'(dut.lfsr), 8'hA5);
    step();
    step();
    #3 Reset = 1'b0;

    // start a game: RUN after one edge, first spawn 200 edges later
    play_flag = 1'b1;
    step();
    check_eq("enter_run", int'(q_Run), 1);
    run_until_spawn(n, 400);
    check_eq("first_spawn_lat", n, 200);
    step();
    check_eq("cnt_after_spawn", int'(dut.interval_cnt), 1);

    // level 0 -> 1 after 16 spawns
    for (int i = 1; i < 16; i++) begin
      run_until_spawn(n, 400);
      check_eq("gap_l0", n, (i == 1) ? 199 : 200);
    end
    check_eq("level_after_16", int'(level), 1);
    check_eq("total_after_16", int'(spawn_total), 16);
    run_until_spawn(n, 400);
    check_eq("gap_l1", n, 150);

    // level 1 allows at most one busy lane
    lane_busy = 4'h3;
    k = 0;
    while (!m_at_last() && k < 300) begin step(); k++; end
    check_eq("reach_blocked", int'(m_at_last()), 1);
    for (int i = 0; i < 3; i++) step();
    check_eq("blocked_pending", int'(pending), 1);
    check_eq("blocked_spawn", int'(spawn), 0);
    lane_busy = 4'h1;
    step();
    check_eq("unblock_spawn", int'(spawn != 4'h0), 1);
    check_eq("avoid_busy", int'(spawn & 4'h1), 0);
    lane_busy = 4'h0;

    // random lane occupancy, game keeps running
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 7) == 0)
        lane_busy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step();
    end

    // push to the hardest level
    lane_busy = 4'h0;
    k = 0;
    while (m_level < 3 && k < 12000) begin step(); k++; end
    check_eq("reach_level3", m_level, 3);

    // all lanes busy past the interval, then only lane L free
    lane_busy = 4'hF;
    k = 0;
    while (!m_at_last() && k < 200) begin step(); k++; end
    step();
    step();
    check_eq("full_pending", int'(pending), 1);
    check_eq("full_spawn", int'(spawn), 0);
    lane_busy = 4'hB;
    step();
    check_eq("spawn_B", int'(spawn), 4'h4);
    check_eq("pending_B", int'(pending), 0);
    lane_busy = 4'h0;

    // game over on the deciding edge
    k = 0;
    while (!m_at_last() && k < 200) begin step(); k++; end
    game_over = 1'b1;
    step();
    check_eq("go_spawn", int'(spawn), 0);
    check_eq("go_halt", int'(q_Halt), 1);
    game_over = 1'b0;
    step();
    play_flag = 1'b0;
    step();
    check_eq("halt_to_idle", int'(q_Idle), 1);
    play_flag = 1'b1;
    step();
    check_eq("restart_level", int'(level), 0);
    check_eq("restart_total", int'(spawn_total), 0);

    // random game-over and play toggling
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0)
        lane_busy = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      game_over = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) play_flag = ~play_flag;
      step();
    end

    // reset in the middle of an interval
    game_over = 1'b0; lane_busy = 4'h0; play_flag = 1'b0;
    step();
    step();
    play_flag = 1'b1;
    step();
    k = 0;
    while (!(ms == 1 && m_cnt == 120) && k < 300) begin step(); k++; end
    check_eq("reach_cnt120", m_cnt, 120);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    check_eq("mid_reset_lfsr", int'(dut.lfsr), 8'hA5);
    check_eq("mid_reset_cnt", int'(dut.interval_cnt), 0);
    step();
    #2 Reset = 1'b0;
    play_flag = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("idle_after_reset", int'(q_Idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
